cache_perf_counter_bank: RTL and testbench

- Parametrised event-counter bank for cache statistics. It generalises the fixed hit/miss/writeback counter set to N_EVENTS channels of configurable width.
- Adds:
  - a shadow snapshot bank for coherent readout while counting continues
  - wrap or saturate overflow handling with sticky overflow flags
  - atomic snapshot-and-clear
  - a valid/ready command port with registered read data
- Sits beside the cache controller. The cache drives one event strobe per channel, and the software/debug interface reads results through the command port.

---
 rtl/cache_perf_counter_bank.sv | 156 +++++++++++++++
 tb/tb_cache_perf_counter_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_perf_counter_bank.sv
// Event-counter bank for cache statistics: live counters, a coherent snapshot bank,
// sticky overflow flags and a valid/ready command port with registered read data.
//
// state | meaning
// IDLE  | ready for a command; SNAPSHOT/CLEAR ops execute here
// RESP  | READ accepted last cycle; rdata_o loads and rdata_valid_o pulses
module cache_perf_counter_bank #(
    parameter int          N_EVENTS   = 8,
    parameter int          COUNTER_BW = 64,
    parameter int          SATURATE   = 0,
    parameter logic [31:0] CACHE_ID   = 32'h0
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                count_en_i,
    input  logic [N_EVENTS-1:0] event_i,
    input  logic                cmd_valid_i,
    input  logic [1:0]          cmd_op_i,
    input  logic [7:0]          cmd_addr_i,
    output logic                cmd_ready_o,
    output logic [31:0]         rdata_o,
    output logic                rdata_valid_o,
    output logic [N_EVENTS-1:0] overflow_o
);

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    localparam logic [1:0] OP_READ      = 2'b00;
    localparam logic [1:0] OP_SNAP      = 2'b01;
    localparam logic [1:0] OP_CLEAR     = 2'b10;
    localparam logic [1:0] OP_SNAP_CLR  = 2'b11;

    state_t                state_q, state_d;
    logic [COUNTER_BW-1:0] live_q   [N_EVENTS];
    logic [COUNTER_BW-1:0] snap_q   [N_EVENTS];
    logic [COUNTER_BW-1:0] live_nxt [N_EVENTS];
    logic [N_EVENTS-1:0]   live_ovf;
    logic [COUNTER_BW-1:0] wall_q, wall_nxt, snap_wall_q;
    logic [7:0]            resp_addr_q;
    logic                  accept, do_read, do_snap, do_clear, resp_load;
    logic [6:0]            rd_idx;
    logic [63:0]           rd_sel;
    logic [31:0]           rd_word;

    function automatic logic [COUNTER_BW-1:0] bump(input logic [COUNTER_BW-1:0] v,
                                                   input logic inc);
        if (inc && (&v))
            return (SATURATE != 0) ? v : '0;
        return v + COUNTER_BW'(inc);
    endfunction

    assign accept   = cmd_valid_i && cmd_ready_o;
    assign do_read  = accept && (cmd_op_i == OP_READ);
    assign do_snap  = accept && ((cmd_op_i == OP_SNAP) || (cmd_op_i == OP_SNAP_CLR));
    assign do_clear = accept && ((cmd_op_i == OP_CLEAR) || (cmd_op_i == OP_SNAP_CLR));

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (do_read) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == ST_IDLE);
        resp_load   = (state_q == ST_RESP);
    end

    always_comb begin
        for (int i = 0; i < N_EVENTS; i++) begin
            live_nxt[i] = bump(live_q[i], event_i[i]);
            live_ovf[i] = event_i[i] && (&live_q[i]);
        end
        wall_nxt = bump(wall_q, 1'b1);
    end

    // Clear wins over counting so same-cycle events are dropped.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < N_EVENTS; i++)
                live_q[i] <= '0;
            wall_q     <= '0;
            overflow_o <= '0;
        end else if (do_clear) begin
            for (int i = 0; i < N_EVENTS; i++)
                live_q[i] <= '0;
            wall_q     <= '0;
            overflow_o <= '0;
        end else if (count_en_i) begin
            for (int i = 0; i < N_EVENTS; i++)
                live_q[i] <= live_nxt[i];
            wall_q     <= wall_nxt;
            overflow_o <= overflow_o | live_ovf;
        end
    end

    // Snapshot captures pre-increment live values.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < N_EVENTS; i++)
                snap_q[i] <= '0;
            snap_wall_q <= '0;
        end else if (do_snap) begin
            for (int i = 0; i < N_EVENTS; i++)
                snap_q[i] <= live_q[i];
            snap_wall_q <= wall_q;
        end else if (do_clear) begin
            for (int i = 0; i < N_EVENTS; i++)
                snap_q[i] <= '0;
            snap_wall_q <= '0;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i)
            resp_addr_q <= '0;
        else if (do_read)
            resp_addr_q <= cmd_addr_i;
    end

    always_comb begin
        rd_idx = resp_addr_q[7:1];
        rd_sel = '0;
        for (int i = 0; i < N_EVENTS; i++)
            if (rd_idx == 7'(i))
                rd_sel = 64'(snap_q[i]);
        if (rd_idx == 7'(N_EVENTS))
            rd_sel = 64'(snap_wall_q);
        rd_word = resp_addr_q[0] ? rd_sel[63:32] : rd_sel[31:0];
        if (resp_addr_q == 8'hFE)
            rd_word = CACHE_ID;
        else if (resp_addr_q == 8'hFF)
            rd_word = 32'(overflow_o);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            rdata_valid_o <= resp_load;
            if (resp_load)
                rdata_o <= rd_word;
        end
    end

endmodule

// File: tb/tb_cache_perf_counter_bank.sv
// Directed bench: a 64-bit wrapping bank plus 4-bit wrapping and saturating banks
// driven with identical stimulus.
module tb_cache_perf_counter_bank;

    localparam logic [31:0] CID = 32'hCAC4_E001;

    logic        clk = 1'b0;
    logic        rstn;
    logic        count_en;
    logic [7:0]  ev;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;

    logic        rdy_m, rdy_w, rdy_s;
    logic [31:0] rd_m, rd_w, rd_s;
    logic        vld_m, vld_w, vld_s;
    logic [7:0]  ovf_m, ovf_w, ovf_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cache_perf_counter_bank #(.N_EVENTS(8), .COUNTER_BW(64), .SATURATE(0), .CACHE_ID(CID)) dut_m (
        .clock_i(clk), .resetn_i(rstn), .count_en_i(count_en), .event_i(ev),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr),
        .cmd_ready_o(rdy_m), .rdata_o(rd_m), .rdata_valid_o(vld_m), .overflow_o(ovf_m));

    cache_perf_counter_bank #(.N_EVENTS(8), .COUNTER_BW(4), .SATURATE(0)) dut_w (
        .clock_i(clk), .resetn_i(rstn), .count_en_i(count_en), .event_i(ev),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr),
        .cmd_ready_o(rdy_w), .rdata_o(rd_w), .rdata_valid_o(vld_w), .overflow_o(ovf_w));

    cache_perf_counter_bank #(.N_EVENTS(8), .COUNTER_BW(4), .SATURATE(1)) dut_s (
        .clock_i(clk), .resetn_i(rstn), .count_en_i(count_en), .event_i(ev),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr),
        .cmd_ready_o(rdy_s), .rdata_o(rd_s), .rdata_valid_o(vld_s), .overflow_o(ovf_s));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        count_en  = 1'b0;
        ev        = '0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        #3;
        rstn = 1'b1;
        tick();
    endtask

    task automatic cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count(input logic [7:0] e, input int n);
        count_en = 1'b1;
        ev       = e;
        for (int i = 0; i < n; i++) tick();
        count_en = 1'b0;
        ev       = '0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] dm,
                           output logic [31:0] dw, output logic [31:0] ds);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = a;
        tick();
        cmd_valid = 1'b0;
        tick();
        check($sformatf("rvalid@%0h", a), {61'd0, vld_m, vld_w, vld_s}, 64'h7);
        dm = rd_m;
        dw = rd_w;
        ds = rd_s;
    endtask

    task automatic read_m(input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] dm, dw, ds;
        do_read(a, dm, dw, ds);
        check($sformatf("read_m@%0h", a), 64'(dm), 64'(exp));
    endtask

    initial begin
        logic [31:0] dm, dw, ds;

        do_reset();
        check("reset_ready", {61'd0, rdy_m, rdy_w, rdy_s}, 64'h7);
        check("reset_valid", {61'd0, vld_m, vld_w, vld_s}, 64'h0);
        check("reset_rdata", 64'(rd_m), 64'h0);
        check("reset_ovf", {40'd0, ovf_m, ovf_w, ovf_s}, 64'h0);

        // Channel readout
        count(8'b0000_0101, 3);
        count(8'b0000_0001, 2);
        cmd(2'b01);
        read_m(8'h00, 32'd5);
        read_m(8'h04, 32'd3);
        read_m(8'h01, 32'd0);
        read_m(8'h02, 32'd0);

        // Walltime and fixed addresses
        do_reset();
        count(8'h00, 100);
        cmd(2'b01);
        read_m(8'h10, 32'd100);
        read_m(8'h11, 32'd0);
        read_m(8'hFE, CID);
        read_m(8'h30, 32'd0);

        // Overflow: 17 events on ch0
        do_reset();
        count(8'h01, 17);
        cmd(2'b01);
        do_read(8'h00, dm, dw, ds);
        check("ovf_cnt_m", 64'(dm), 64'd17);
        check("ovf_cnt_wrap", 64'(dw), 64'd1);
        check("ovf_cnt_sat", 64'(ds), 64'd15);
        do_read(8'hFF, dm, dw, ds);
        check("ovf_flag_m", 64'(dm), 64'd0);
        check("ovf_flag_wrap", 64'(dw), 64'd1);
        check("ovf_flag_sat", 64'(ds), 64'd1);
        check("ovf_port", {40'd0, ovf_m, ovf_w, ovf_s}, 64'h00_0101);
        cmd(2'b10);
        do_read(8'hFF, dm, dw, ds);
        check("clr_flag_wrap", 64'(dw), 64'd0);
        check("clr_flag_sat", 64'(ds), 64'd0);
        check("clr_port", {40'd0, ovf_m, ovf_w, ovf_s}, 64'h0);

        // Handshake with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 8'hFE;
        tick();
        check("hs_ready_t", 64'(rdy_m), 64'd0);
        check("hs_valid_t", 64'(vld_m), 64'd0);
        tick();
        check("hs_valid_t1", 64'(vld_m), 64'd1);
        check("hs_data_t1", 64'(rd_m), 64'(CID));
        check("hs_ready_t1", 64'(rdy_m), 64'd1);
        tick();
        check("hs_ready_t2", 64'(rdy_m), 64'd0);
        check("hs_valid_t2", 64'(vld_m), 64'd0);
        cmd_valid = 1'b0;
        tick();
        check("hs_valid_t3", 64'(vld_m), 64'd1);

        // Snapshot isolation; snapshot taken in a cycle with an event
        do_reset();
        count(8'h02, 4);
        count_en  = 1'b1;
        ev        = 8'h02;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        tick();
        cmd_valid = 1'b0;
        count(8'h02, 5);
        read_m(8'h02, 32'd4);
        count_en  = 1'b1;
        ev        = 8'h02;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        tick();
        cmd_valid = 1'b0;
        count_en  = 1'b0;
        ev        = '0;
        read_m(8'h02, 32'd10);
        cmd(2'b01);
        read_m(8'h02, 32'd0);

        // Reset during a pending read
        count(8'h01, 3);
        cmd(2'b01);
        read_m(8'hFE, CID);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 8'h00;
        tick();
        cmd_valid = 1'b0;
        rstn      = 1'b0;
        tick();
        check("rst_valid", 64'(vld_m), 64'd0);
        check("rst_rdata", 64'(rd_m), 64'd0);
        check("rst_ready", 64'(rdy_m), 64'd1);
        #3;
        rstn = 1'b1;
        tick();
        check("rst_valid_after", 64'(vld_m), 64'd0);
        read_m(8'h00, 32'd0);
        read_m(8'h10, 32'd0);
        read_m(8'hFF, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
